// File: rtl/mcu_seq_pkg.sv
// Shared types for the MCU sequencer: stage encodings visible on the stage port.
package mcu_seq_pkg;

   typedef enum logic [2:0] {
      StLoad    = 3'd0,
      StFetch   = 3'd1,
      StDecode  = 3'd2,
      StExecute = 3'd3,
      StHalt    = 3'd4
   } stage_t;

endpackage

// File: rtl/mcu_seq_loader.sv
// Boot image loader: accepts image words while active and replays each one
// as a registered program-memory write on the following cycle.
module mcu_seq_loader #(
   parameter int unsigned IW         = 14,
   parameter int unsigned AW         = 8,
   parameter int unsigned PMEM_DEPTH = 10
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          active_i,
   input  logic          img_valid_i,
   input  logic [IW-1:0] img_data_i,
   output logic          img_ready_o,
   output logic          load_last_o,
   output logic          pmem_we_o,
   output logic [AW-1:0] pmem_waddr_o,
   output logic [IW-1:0] pmem_wdata_o,
   output logic          load_done_o
);

   localparam logic [AW-1:0] LastIdx = AW'(PMEM_DEPTH - 1);

   logic [AW-1:0] count_q, count_d;
   logic [AW-1:0] waddr_q;
   logic [IW-1:0] wdata_q;
   logic          we_q, done_q, done_d;
   logic          accept;

   always_comb begin
      accept      = active_i & img_valid_i;
      img_ready_o = active_i;
      load_last_o = accept & (count_q == LastIdx);
      count_d     = count_q;
      done_d      = done_q | load_last_o;
      if (accept) begin
         count_d = load_last_o ? '0 : count_q + AW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
         we_q    <= accept;
         if (accept) begin
            waddr_q <= count_q;
            wdata_q <= img_data_i;
         end
      end
   end

   assign pmem_we_o    = we_q;
   assign pmem_waddr_o = waddr_q;
   assign pmem_wdata_o = wdata_q;
   assign load_done_o  = done_q;

endmodule

// File: rtl/mcu_sequencer.sv
// MCU control path: boot loader, FETCH/DECODE/EXECUTE stage FSM, PC/IR,
// and single-level interrupt entry/return with halt and watchdog restart.
module mcu_sequencer
   import mcu_seq_pkg::*;
#(
   parameter int unsigned   IW         = 14,
   parameter int unsigned   AW         = 8,
   parameter int unsigned   PMEM_DEPTH = 10,
   parameter logic [AW-1:0] IRQ_VECTOR = AW'(8'hF0)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wdt_rst,
   input  logic          img_valid,
   input  logic [IW-1:0] img_data,
   output logic          img_ready,
   output logic          pmem_we,
   output logic [AW-1:0] pmem_waddr,
   output logic [IW-1:0] pmem_wdata,
   output logic          pmem_re,
   output logic [AW-1:0] pmem_raddr,
   input  logic [IW-1:0] pmem_rdata,
   output logic [2:0]    stage,
   output logic [AW-1:0] pc,
   output logic [IW-1:0] ir,
   output logic          exec_first,
   input  logic          stall,
   input  logic          branch_take,
   input  logic [AW-1:0] branch_target,
   input  logic          iret,
   input  logic          halt,
   input  logic          irq,
   output logic          irq_ack,
   output logic          load_done
);

   stage_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d, epc_q, epc_d, npc;
   logic [IW-1:0] ir_q, ir_d;
   logic          ie_q, ie_d, irq_ack_q, irq_ack_d, exec_first_q, exec_first_d;
   logic          clr, load_last, take_irq;

   assign clr = rst | wdt_rst;

   mcu_seq_loader #(
      .IW         (IW),
      .AW         (AW),
      .PMEM_DEPTH (PMEM_DEPTH)
   ) u_loader (
      .clk_i        (clk),
      .rst_i        (clr),
      .active_i     (state_q == StLoad),
      .img_valid_i  (img_valid),
      .img_data_i   (img_data),
      .img_ready_o  (img_ready),
      .load_last_o  (load_last),
      .pmem_we_o    (pmem_we),
      .pmem_waddr_o (pmem_waddr),
      .pmem_wdata_o (pmem_wdata),
      .load_done_o  (load_done)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      epc_d        = epc_q;
      ie_d         = ie_q;
      irq_ack_d    = 1'b0;
      exec_first_d = 1'b0;
      take_irq     = irq & ie_q;

      if (iret)             npc = epc_q;
      else if (branch_take) npc = branch_target;
      else                  npc = pc_q + AW'(1);

      case (state_q)
         StLoad: begin
            if (load_last) begin
               state_d = StFetch;
               pc_d    = '0;
            end
         end
         StFetch:  state_d = StDecode;
         StDecode: begin
            ir_d         = pmem_rdata;
            exec_first_d = 1'b1;
            state_d      = StExecute;
         end
         StExecute: begin
            if (!stall) begin
               // iret wins over a pending request so the return always completes
               if (take_irq && !iret) begin
                  epc_d     = npc;
                  pc_d      = IRQ_VECTOR;
                  ie_d      = 1'b0;
                  irq_ack_d = 1'b1;
                  state_d   = StFetch;
               end else begin
                  pc_d    = npc;
                  ie_d    = ie_q | iret;
                  state_d = halt ? StHalt : StFetch;
               end
            end
         end
         StHalt: begin
            if (take_irq) begin
               epc_d     = pc_q;
               pc_d      = IRQ_VECTOR;
               ie_d      = 1'b0;
               irq_ack_d = 1'b1;
               state_d   = StFetch;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= StLoad;
         pc_q         <= '0;
         ir_q         <= '0;
         epc_q        <= '0;
         ie_q         <= 1'b1;
         irq_ack_q    <= 1'b0;
         exec_first_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         epc_q        <= epc_d;
         ie_q         <= ie_d;
         irq_ack_q    <= irq_ack_d;
         exec_first_q <= exec_first_d;
      end
   end

   assign stage      = state_q;
   assign pmem_re    = (state_q == StFetch);
   assign pmem_raddr = pc_q;
   assign pc         = pc_q;
   assign ir         = ir_q;
   assign exec_first = exec_first_q;
   assign irq_ack    = irq_ack_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Randomized self-checking bench for mcu_sequencer against an instruction-level
// model of PC, EPC and interrupt-enable.
module tb_mcu_sequencer;

   localparam int          IW    = 14;
   localparam int          DEPTH = 10;
   localparam logic [7:0]  VEC   = 8'hF0;
   localparam int S_LOAD = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3, S_HALT = 4;

   logic          clk = 1'b0;
   logic          rst, wdt_rst, img_valid, img_ready;
   logic [IW-1:0] img_data, pmem_wdata, pmem_rdata, ir;
   logic          pmem_we, pmem_re, exec_first, stall, branch_take, iret, halt, irq;
   logic          irq_ack, load_done;
   logic [7:0]    pmem_waddr, pmem_raddr, pc, branch_target;
   logic [2:0]    stage;

   logic [IW-1:0] img  [256];
   logic [IW-1:0] lmem [256];

   int         checks = 0;
   int         failures = 0;
   logic [7:0] m_pc, m_epc;
   bit         m_ie;

   always #5 clk = ~clk;

   mcu_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .wdt_rst       (wdt_rst),
      .img_valid     (img_valid),
      .img_data      (img_data),
      .img_ready     (img_ready),
      .pmem_we       (pmem_we),
      .pmem_waddr    (pmem_waddr),
      .pmem_wdata    (pmem_wdata),
      .pmem_re       (pmem_re),
      .pmem_raddr    (pmem_raddr),
      .pmem_rdata    (pmem_rdata),
      .stage         (stage),
      .pc            (pc),
      .ir            (ir),
      .exec_first    (exec_first),
      .stall         (stall),
      .branch_take   (branch_take),
      .branch_target (branch_target),
      .iret          (iret),
      .halt          (halt),
      .irq           (irq),
      .irq_ack       (irq_ack),
      .load_done     (load_done)
   );

   // Program memory: loaded words come from DUT writes, the rest from the image table.
   always @(posedge clk) begin
      if (pmem_we) lmem[pmem_waddr] <= pmem_wdata;
      if (pmem_re) pmem_rdata <= (pmem_raddr < DEPTH) ? lmem[pmem_raddr] : img[pmem_raddr];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check_val({tag, "_stage"}, stage, S_LOAD);
      check_val({tag, "_pc"}, pc, 0);
      check_val({tag, "_ir"}, ir, 0);
      check_val({tag, "_done"}, load_done, 0);
      check_val({tag, "_we"}, pmem_we, 0);
      check_val({tag, "_re"}, pmem_re, 0);
      check_val({tag, "_xf"}, exec_first, 0);
      check_val({tag, "_ack"}, irq_ack, 0);
      check_val({tag, "_rdy"}, img_ready, 1);
      m_pc  = 8'h00;
      m_epc = 8'h00;
      m_ie  = 1'b1;
   endtask

   task automatic boot(input int abort_at);
      int i = 0;
      int abort = abort_at;
      while (i < DEPTH) begin
         img_data  = img[i];
         img_valid = ($urandom_range(3) != 0);
         if (i == abort) begin
            img_valid = 1'b1;
            wdt_rst   = 1'b1;
            tick();
            wdt_rst   = 1'b0;
            img_valid = 1'b0;
            check_reset_state("wdt_load");
            i     = 0;
            abort = -1;
            continue;
         end
         tick();
         if (img_valid) begin
            check_val("ld_we", pmem_we, 1);
            check_val("ld_waddr", pmem_waddr, i);
            check_val("ld_wdata", pmem_wdata, img[i]);
            i++;
         end else begin
            check_val("ld_idle_we", pmem_we, 0);
         end
      end
      img_valid = 1'b0;
      check_val("boot_stage", stage, S_FETCH);
      check_val("boot_done", load_done, 1);
      check_val("boot_rdy", img_ready, 0);
      check_val("boot_pc", pc, 0);
   endtask

   task automatic handle_halt();
      int n = $urandom_range(12, 1);
      for (int k = 0; k < n; k++) begin
         tick();
         check_val("halt_stage", stage, S_HALT);
         check_val("halt_re", pmem_re, 0);
         check_val("halt_ack", irq_ack, 0);
         check_val("halt_pc", pc, m_pc);
      end
      irq = 1'b1;
      tick();
      irq = 1'b0;
      if (m_ie) begin
         m_epc = m_pc;
         m_pc  = VEC;
         m_ie  = 1'b0;
         check_val("wake_stage", stage, S_FETCH);
         check_val("wake_ack", irq_ack, 1);
         check_val("wake_pc", pc, VEC);
      end else begin
         check_val("halt_noie_stage", stage, S_HALT);
         check_val("halt_noie_ack", irq_ack, 0);
         wdt_rst = 1'b1;
         tick();
         wdt_rst = 1'b0;
         check_reset_state("wdt_halt");
         boot(-1);
      end
   endtask

   task automatic run_instr(input int nstall, input bit br, input logic [7:0] tgt,
                            input bit ir_t, input bit hl, input bit irqv);
      logic [7:0] npc;
      bit         take;
      int         exp_stage;
      check_val("f_stage", stage, S_FETCH);
      check_val("f_re", pmem_re, 1);
      check_val("f_raddr", pmem_raddr, m_pc);
      irq = irqv;
      tick();
      check_val("d_stage", stage, S_DECODE);
      check_val("d_re", pmem_re, 0);
      check_val("d_ack", irq_ack, 0);
      tick();
      check_val("e_stage", stage, S_EXEC);
      check_val("e_first", exec_first, 1);
      check_val("e_ir", ir, img[m_pc]);
      for (int k = 0; k < nstall; k++) begin
         stall = 1'b1;
         tick();
         check_val("st_stage", stage, S_EXEC);
         check_val("st_first", exec_first, 0);
         check_val("st_pc", pc, m_pc);
         check_val("st_ack", irq_ack, 0);
      end
      stall         = 1'b0;
      branch_take   = br;
      branch_target = tgt;
      iret          = ir_t;
      halt          = hl;
      tick();
      branch_take = 1'b0;
      iret        = 1'b0;
      halt        = 1'b0;
      irq         = 1'b0;
      npc  = ir_t ? m_epc : (br ? tgt : m_pc + 8'd1);
      take = irqv && m_ie && !ir_t;
      if (take) begin
         m_epc     = npc;
         m_pc      = VEC;
         m_ie      = 1'b0;
         exp_stage = S_FETCH;
      end else begin
         m_pc      = npc;
         if (ir_t) m_ie = 1'b1;
         exp_stage = hl ? S_HALT : S_FETCH;
      end
      check_val("x_stage", stage, exp_stage);
      check_val("x_pc", pc, m_pc);
      check_val("x_ack", irq_ack, take);
      if (exp_stage == S_HALT) handle_halt();
   endtask

   task automatic stall_restart(input bit both);
      check_val("sr_stage", stage, S_FETCH);
      tick();
      tick();
      stall = 1'b1;
      tick();
      tick();
      rst     = both;
      wdt_rst = 1'b1;
      tick();
      rst     = 1'b0;
      wdt_rst = 1'b0;
      stall   = 1'b0;
      check_reset_state(both ? "rst_both" : "wdt_stall");
      boot(-1);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      for (int a = 0; a < 256; a++) img[a] = IW'($urandom);
      rst = 1'b1; wdt_rst = 1'b0; img_valid = 1'b0; img_data = '0;
      stall = 1'b0; branch_take = 1'b0; branch_target = '0;
      iret = 1'b0; halt = 1'b0; irq = 1'b0;
      @(negedge clk);
      tick();
      rst = 1'b0;
      check_reset_state("reset");
      boot(4);

      run_instr(0, 0, 8'h00, 0, 0, 0);
      run_instr(0, 0, 8'h00, 0, 0, 0);
      run_instr(0, 0, 8'h00, 0, 0, 0);
      run_instr(4, 1, 8'h20, 0, 0, 0);
      run_instr(0, 1, 8'hFF, 0, 0, 0);
      run_instr(0, 0, 8'h00, 0, 0, 0);
      check_val("wrap_pc", pc, 8'h00);
      run_instr(0, 1, 8'h05, 0, 0, 0);
      run_instr(0, 0, 8'h00, 0, 0, 1);
      check_val("irq_epc_model", m_epc, 8'h06);
      run_instr(0, 0, 8'h00, 0, 0, 1);
      run_instr(0, 0, 8'h00, 1, 0, 0);
      check_val("iret_pc", pc, 8'h06);
      run_instr(0, 0, 8'h00, 0, 0, 0);
      run_instr(0, 0, 8'h00, 0, 1, 0);
      run_instr(0, 0, 8'h00, 1, 0, 0);
      check_val("halt_ret_pc", pc, 8'h08);
      stall_restart(1'b0);
      stall_restart(1'b1);

      for (int n = 0; n < 200; n++) begin
         run_instr(($urandom_range(3) == 0) ? int'($urandom_range(4, 1)) : 0,
                   $urandom_range(4) == 0, 8'($urandom), $urandom_range(9) == 0,
                   $urandom_range(19) == 0, $urandom_range(4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
Parametrised successor to the microcontroller's LOAD/FETCH/DECODE/EXECUTE control path. It owns the program loader, PC, IR, stage FSM, and interrupt entry/return. It also supports execute stalls for slow peripherals (UART/timer), halt/wake, and watchdog restart. Datapath, ALU and instruction decode stay external and attach through strobes and decode-result inputs.

Parameters:
IW, 14, instruction width (bits)
AW, 8, program address / PC width
PMEM_DEPTH, 10, words loaded at boot; must be 1..2^AW
IRQ_VECTOR, 8'hF0, interrupt entry address (AW bits)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wdt_rst  in  1  watchdog restart: re-enter LOAD
img_valid  in  1  boot image word valid
img_data  in  IW  boot image word
img_ready  out  1  loader accepts word (high only in LOAD)
pmem_we  out  1  program memory write strobe
pmem_waddr  out  AW  write address
pmem_wdata  out  IW  write data
pmem_re  out  1  program memory read strobe (FETCH)
pmem_raddr  out  AW  read address (= PC)
pmem_rdata  in  IW  read data, valid the cycle after pmem_re
stage  out  3  current state encoding (package constants)
pc  out  AW  program counter
ir  out  IW  instruction register
exec_first  out  1  one-cycle pulse on the first EXECUTE cycle of each instruction
stall  in  1  hold in EXECUTE while high
branch_take  in  1  decode: take branch (sampled on EXECUTE exit)
branch_target  in  AW  branch destination
iret  in  1  decode: return from interrupt
halt  in  1  decode: enter HALT after this instruction
irq  in  1  level interrupt request
irq_ack  out  1  one-cycle pulse on interrupt entry
load_done  out  1  high once the boot image is complete; cleared by rst/wdt_rst

Behaviour:
- Reset (rst): next cycle state=LOAD, load count=0, pc=0, ir=0, epc=0, ie=1, load_done=0. All strobes 0: pmem_we, pmem_re, exec_first, irq_ack.
- rst has priority over wdt_rst. wdt_rst has the same effect as rst and overrides every state, including mid-load (count restarts at 0) and mid-stall.
- LOAD: img_ready=1. Each accepted word (img_valid & img_ready) is registered: next cycle pmem_we=1, pmem_waddr=count, pmem_wdata=img_data. count then increments.
  - On the accept with count==PMEM_DEPTH-1: next cycle state=FETCH, pc=0, load_done=1, img_ready=0.
  - The final pmem_we coincides with the first FETCH cycle.
- FETCH: 1 cycle. pmem_re=1, pmem_raddr=pc.
- DECODE: 1 cycle. ir <= pmem_rdata (captured at the end of this cycle).
- EXECUTE: exec_first=1 on the first cycle only. While stall=1 the FSM stays in EXECUTE and pc/ir hold. A non-stalled instruction takes exactly 3 cycles (F, D, E).
- EXECUTE exit (stall=0) computes npc, with priority iret > branch_take > sequential:
  - iret: npc=epc, ie<=1.
  - branch_take: npc=branch_target.
  - otherwise: npc=pc+1 mod 2^AW (pc=2^AW-1 wraps to 0).
- Interrupt check at EXECUTE exit: if irq & ie & !iret, then epc<=npc, pc<=IRQ_VECTOR, ie<=0, irq_ack=1 for one cycle, next state FETCH. Otherwise pc<=npc.
- halt=1 at exit (and no interrupt taken): pc<=npc, state=HALT.
- HALT: no strobes. Stays in HALT until irq & ie, which causes interrupt entry (epc<=pc, pc<=IRQ_VECTOR, irq_ack, state FETCH). With ie=0, only rst/wdt_rst leave HALT.
- Interrupts are non-nesting (single level, single epc). irq is ignored in LOAD, FETCH, DECODE and while stalled.
- Decode inputs are sampled only on the EXECUTE exit cycle. iret while ie=1 still loads epc.

Decomposition:
- Package mcu_seq_pkg: stage encodings LOAD=3'd0, FETCH=3'd1, DECODE=3'd2, EXECUTE=3'd3, HALT=3'd4, plus a stage_t typedef.
- One sub-module, mcu_seq_loader: load counter, img handshake, registered pmem write port, load_done.
- FSM, PC/IR/epc/ie logic lives in the top module.

Test Plan:
- Boot: rst 1 cycle, then 10 back-to-back img words 0x0001..0x000A → pmem_we pulses at waddr 0..9 with matching data; stage=FETCH the cycle after the 10th accept; pc=0; load_done=1.
- Straight line: pmem_rdata = address, no stalls → pc steps 0,1,2,… every 3 cycles; ir equals the previous pc; exec_first pulses once per instruction. Start at pc=0xFF → next pc=0x00.
- Branch/stall: at pc=3 assert stall for 4 cycles, then branch_take=1 with target 0x20 → EXECUTE lasts 5 cycles with exec_first high only on the first; next pc=0x20.
- Interrupt: irq=1 during execute at pc=5 → irq_ack 1 cycle, pc=0xF0, epc=6. Second irq while ie=0 is ignored. iret at exit → pc=6, ie=1.
- Halt/wake: halt at pc=7 → stage=HALT, pc=8. irq after 10 cycles → irq_ack, pc=0xF0; iret later returns to 8.
- Restart: wdt_rst at mid-load count 4, and again mid-stall → next cycle stage=LOAD, count=0, pc=0, load_done=0. rst and wdt_rst together → identical reset state.
